rgb_fade_sequencer: RTL

Autonomous colour sequencer in front of the three-channel PWM LED driver. It steps through a 4-entry programmable colour table and ramps each channel's duty level by one LSB per step tick toward the active entry. It holds each colour for a programmable time, then advances to the next entry. Outputs are per-channel duty levels plus a change strobe, consumed by the PWM stage in place of the manual encoder path.

---
 rtl/rgb_seq_pkg.sv | 40 ++++
 rtl/rgb_fade_sequencer_if.sv | 29 ++
 rtl/rgb_seq_prescaler.sv | 26 ++
 rtl/rgb_fade_sequencer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/rgb_seq_pkg.sv
// rtl/rgb_seq_pkg.sv - shared types, constants and step helper for the colour fade sequencer
// Contents: state_t FSM encoding, NUM_COLORS, color_t table entry, DEFAULT_TABLE reset contents,
//           step_chan() single-channel one-LSB move toward a target.
package rgb_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RAMP = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam int NUM_COLORS     = 4;
    localparam int DEFAULT_DUTY_W = 8;

    typedef struct packed {
        logic [DEFAULT_DUTY_W-1:0] red;
        logic [DEFAULT_DUTY_W-1:0] green;
        logic [DEFAULT_DUTY_W-1:0] blue;
    } color_t;

    // Non-zero channels here mean "full scale" at whatever DUTY_W the top is built with.
    localparam color_t DEFAULT_TABLE [NUM_COLORS] = '{
        '{red: 8'hFF, green: 8'h00, blue: 8'h00},
        '{red: 8'h00, green: 8'hFF, blue: 8'h00},
        '{red: 8'h00, green: 8'h00, blue: 8'hFF},
        '{red: 8'hFF, green: 8'hFF, blue: 8'hFF}
    };

    // One step toward the target; saturates at the target, never overshoots or wraps.
    function automatic int unsigned step_chan(input int unsigned cur, input int unsigned tgt);
        if (cur < tgt) begin
            return cur + 1;
        end else if (cur > tgt) begin
            return cur - 1;
        end
        return cur;
    endfunction

endpackage

// File: rtl/rgb_fade_sequencer_if.sv
// rtl/rgb_fade_sequencer_if.sv - control, table-write and duty-output bundle of the colour sequencer
// master: drives enable and the cfg_* table write port, observes duty_*, duty_valid, color_idx, busy.
// slave:  the sequencer itself.
interface rgb_fade_sequencer_if #(
    parameter int DUTY_W = 8
);
    logic              enable;
    logic              cfg_we;
    logic [1:0]        cfg_addr;
    logic [DUTY_W-1:0] cfg_red;
    logic [DUTY_W-1:0] cfg_green;
    logic [DUTY_W-1:0] cfg_blue;
    logic [DUTY_W-1:0] duty_red;
    logic [DUTY_W-1:0] duty_green;
    logic [DUTY_W-1:0] duty_blue;
    logic              duty_valid;
    logic [1:0]        color_idx;
    logic              busy;

    modport master (
        output enable, cfg_we, cfg_addr, cfg_red, cfg_green, cfg_blue,
        input  duty_red, duty_green, duty_blue, duty_valid, color_idx, busy
    );

    modport slave (
        input  enable, cfg_we, cfg_addr, cfg_red, cfg_green, cfg_blue,
        output duty_red, duty_green, duty_blue, duty_valid, color_idx, busy
    );
endinterface

// File: rtl/rgb_seq_prescaler.sv
// rtl/rgb_seq_prescaler.sv - step tick generator, one tick every STEP_DIV clocks while run is high
// Ports: clk, rst (sync active-high), clear (force count to 0), run (count enable),
//        tick (high in the cycle the count equals STEP_DIV-1; count wraps that same cycle).
module rgb_seq_prescaler #(
    parameter int STEP_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic tick
);
    localparam int CW = $clog2(STEP_DIV);

    logic [CW-1:0] cnt_q;

    assign tick = run && (cnt_q == CW'(STEP_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= tick ? '0 : cnt_q + CW'(1);
        end
    end
endmodule

// File: rtl/rgb_fade_sequencer.sv
// rtl/rgb_fade_sequencer.sv - 4-entry colour table sequencer ramping three duty levels one LSB per tick
// Ports: clk, rst (sync active-high), bus (rgb_fade_sequencer_if.slave: enable, cfg_* table write,
//        duty_* levels, duty_valid change strobe, color_idx active entry, busy = not IDLE).
// Option: RGB_SEQ_SKIP_BLACK_EN - LOAD skips all-zero entries, accepting after four consecutive skips.
module rgb_fade_sequencer
    import rgb_seq_pkg::*;
#(
    parameter int DUTY_W     = 8,
    parameter int STEP_DIV   = 1000,
    parameter int HOLD_STEPS = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    rgb_fade_sequencer_if.slave  bus
);
    localparam int HCW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

    typedef logic [DUTY_W-1:0] duty_t;

    state_t         state_q, state_n;
    duty_t          tbl_red   [NUM_COLORS];
    duty_t          tbl_green [NUM_COLORS];
    duty_t          tbl_blue  [NUM_COLORS];
    duty_t          duty_red_q, duty_green_q, duty_blue_q;
    duty_t          duty_red_n, duty_green_n, duty_blue_n;
    duty_t          tgt_red_q, tgt_green_q, tgt_blue_q;
    duty_t          tgt_red_n, tgt_green_n, tgt_blue_n;
    logic           duty_valid_q, duty_valid_n;
    logic [1:0]     idx_q, idx_n;
    logic [HCW-1:0] hold_q, hold_n;
    logic           pre_clear, pre_run, tick;
    logic           at_target;
`ifdef RGB_SEQ_SKIP_BLACK_EN
    logic [2:0]     skip_q, skip_n;
    logic           entry_black;
`endif

    assign pre_run   = (state_q == RAMP) || (state_q == HOLD);
    assign at_target = (duty_red_q == tgt_red_q) && (duty_green_q == tgt_green_q)
                    && (duty_blue_q == tgt_blue_q);

    rgb_seq_prescaler #(.STEP_DIV(STEP_DIV)) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clear (pre_clear),
        .run   (pre_run),
        .tick  (tick)
    );

    // Writes land at the clock edge, so a LOAD in the same cycle still sees the old entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_COLORS; i++) begin
                tbl_red[i]   <= {DUTY_W{DEFAULT_TABLE[i].red   != '0}};
                tbl_green[i] <= {DUTY_W{DEFAULT_TABLE[i].green != '0}};
                tbl_blue[i]  <= {DUTY_W{DEFAULT_TABLE[i].blue  != '0}};
            end
        end else if (bus.cfg_we) begin
            tbl_red[bus.cfg_addr]   <= bus.cfg_red;
            tbl_green[bus.cfg_addr] <= bus.cfg_green;
            tbl_blue[bus.cfg_addr]  <= bus.cfg_blue;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            duty_red_q   <= '0;
            duty_green_q <= '0;
            duty_blue_q  <= '0;
            tgt_red_q    <= '0;
            tgt_green_q  <= '0;
            tgt_blue_q   <= '0;
            duty_valid_q <= 1'b0;
            idx_q        <= '0;
            hold_q       <= '0;
`ifdef RGB_SEQ_SKIP_BLACK_EN
            skip_q       <= '0;
`endif
        end else begin
            state_q      <= state_n;
            duty_red_q   <= duty_red_n;
            duty_green_q <= duty_green_n;
            duty_blue_q  <= duty_blue_n;
            tgt_red_q    <= tgt_red_n;
            tgt_green_q  <= tgt_green_n;
            tgt_blue_q   <= tgt_blue_n;
            duty_valid_q <= duty_valid_n;
            idx_q        <= idx_n;
            hold_q       <= hold_n;
`ifdef RGB_SEQ_SKIP_BLACK_EN
            skip_q       <= skip_n;
`endif
        end
    end

`ifdef RGB_SEQ_SKIP_BLACK_EN
    assign entry_black = (tbl_red[idx_q] == '0) && (tbl_green[idx_q] == '0)
                      && (tbl_blue[idx_q] == '0);
`endif

    always_comb begin
        state_n      = state_q;
        duty_red_n   = duty_red_q;
        duty_green_n = duty_green_q;
        duty_blue_n  = duty_blue_q;
        tgt_red_n    = tgt_red_q;
        tgt_green_n  = tgt_green_q;
        tgt_blue_n   = tgt_blue_q;
        duty_valid_n = 1'b0;
        idx_n        = idx_q;
        hold_n       = hold_q;
        pre_clear    = 1'b0;
`ifdef RGB_SEQ_SKIP_BLACK_EN
        skip_n       = '0;
`endif
        // Dropping enable freezes duties and colour index; only the state falls back.
        if ((state_q != IDLE) && !bus.enable) begin
            state_n = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.enable) begin
                        state_n = LOAD;
                    end
                end
                LOAD: begin
                    tgt_red_n   = tbl_red[idx_q];
                    tgt_green_n = tbl_green[idx_q];
                    tgt_blue_n  = tbl_blue[idx_q];
                    pre_clear   = 1'b1;
                    state_n     = RAMP;
`ifdef RGB_SEQ_SKIP_BLACK_EN
                    // After four skips every entry is black; take the current one anyway.
                    if (entry_black && (skip_q != 3'd4)) begin
                        idx_n   = idx_q + 2'd1;
                        skip_n  = skip_q + 3'd1;
                        state_n = LOAD;
                    end
`endif
                end
                RAMP: begin
                    if (at_target) begin
                        state_n = HOLD;
                        hold_n  = '0;
                    end else if (tick) begin
                        duty_red_n   = DUTY_W'(step_chan(32'(duty_red_q),   32'(tgt_red_q)));
                        duty_green_n = DUTY_W'(step_chan(32'(duty_green_q), 32'(tgt_green_q)));
                        duty_blue_n  = DUTY_W'(step_chan(32'(duty_blue_q),  32'(tgt_blue_q)));
                        duty_valid_n = 1'b1;
                    end
                end
                HOLD: begin
                    if (tick) begin
                        if (hold_q == HCW'(HOLD_STEPS - 1)) begin
                            idx_n   = idx_q + 2'd1;
                            state_n = LOAD;
                        end else begin
                            hold_n = hold_q + HCW'(1);
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign bus.duty_red   = duty_red_q;
    assign bus.duty_green = duty_green_q;
    assign bus.duty_blue  = duty_blue_q;
    assign bus.duty_valid = duty_valid_q;
    assign bus.color_idx  = idx_q;
    assign bus.busy       = (state_q != IDLE);

endmodule
